floor_request_encoder: RTL and testbench

Sequential counterpart to the floor decoders: latches one-hot floor call buttons into a pending-request register and encodes the next floor to serve into a binary target number. It uses a SCAN policy, continuing in the current direction while requests remain ahead of the car. It sits between the call-button inputs and the car motion controller. The binary target it produces is what the controller's decoders expand back to one-hot.

---
 rtl/floor_request_encoder.sv | 130 +++++++++++++
 tb/tb_floor_request_encoder.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/floor_request_encoder.sv
// Latches floor calls and picks the next floor to serve using SCAN order.
// Outputs are registered; the target is held while target_valid is low.
module floor_request_encoder #(
  parameter int FLOORS = 8,
  parameter int FBITS  = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [FLOORS-1:0] call_btn,
  input  logic [FBITS-1:0]  cur_floor,
  input  logic              arrive,
  output logic [FLOORS-1:0] pending,
  output logic [FBITS-1:0]  target,
  output logic              target_valid,
  output logic              moving_up,
  output logic              moving_down
);

  typedef enum logic [1:0] {
    IDLE,
    UP,
    DOWN
  } state_t;

  state_t state;

  logic [FLOORS-1:0] above;
  logic [FLOORS-1:0] below;
  logic [FLOORS-1:0] clr;
  logic              here;
  logic              any_above;
  logic              any_below;
  logic [FBITS-1:0]  lo_above;
  logic [FBITS-1:0]  hi_below;

  // Floors at or beyond FLOORS match no bit, so they clear nothing.
  always_comb begin
    above = '0;
    below = '0;
    clr   = '0;
    here  = 1'b0;
    for (int i = 0; i < FLOORS; i++) begin
      above[i] = pending[i] && (FBITS'(i) > cur_floor);
      below[i] = pending[i] && (FBITS'(i) < cur_floor);
      clr[i]   = arrive && (FBITS'(i) == cur_floor);
      if (pending[i] && (FBITS'(i) == cur_floor))
        here = 1'b1;
    end
  end

  always_comb begin
    lo_above = '0;
    for (int i = FLOORS - 1; i >= 0; i--)
      if (above[i])
        lo_above = FBITS'(i);
  end

  always_comb begin
    hi_below = '0;
    for (int i = 0; i < FLOORS; i++)
      if (below[i])
        hi_below = FBITS'(i);
  end

  assign any_above = |above;
  assign any_below = |below;

  always_ff @(posedge clk) begin
    if (reset) begin
      pending      <= '0;
      state        <= IDLE;
      target       <= '0;
      target_valid <= 1'b0;
    end else begin
      pending <= (pending | call_btn) & ~clr;
      unique case (state)
        IDLE: begin
          if (any_above) begin
            state        <= UP;
            target       <= lo_above;
            target_valid <= 1'b1;
          end else if (any_below) begin
            state        <= DOWN;
            target       <= hi_below;
            target_valid <= 1'b1;
          end else if (here) begin
            target       <= cur_floor;
            target_valid <= 1'b1;
          end else begin
            target_valid <= 1'b0;
          end
        end
        UP: begin
          if (any_above) begin
            target       <= lo_above;
            target_valid <= 1'b1;
          end else if (any_below) begin
            state        <= DOWN;
            target       <= hi_below;
            target_valid <= 1'b1;
          end else begin
            state        <= IDLE;
            target_valid <= 1'b0;
          end
        end
        DOWN: begin
          if (any_below) begin
            target       <= hi_below;
            target_valid <= 1'b1;
          end else if (any_above) begin
            state        <= UP;
            target       <= lo_above;
            target_valid <= 1'b1;
          end else begin
            state        <= IDLE;
            target_valid <= 1'b0;
          end
        end
        default: begin
          state        <= IDLE;
          target_valid <= 1'b0;
        end
      endcase
    end
  end

  assign moving_up   = (state == UP);
  assign moving_down = (state == DOWN);

endmodule

// File: tb/tb_floor_request_encoder.sv
// Scoreboarded bench for floor_request_encoder: SCAN model plus
// directed scenarios, and a 5-floor instance for out-of-range floors.
module tb_floor_request_encoder;

  typedef struct packed {
    logic [7:0] p;
    logic [2:0] t;
    logic       v;
    logic       u;
    logic       d;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] call_btn = '0;
  logic [2:0] cur_floor = '0;
  logic       arrive = 1'b0;
  logic [7:0] pending;
  logic [2:0] target;
  logic       target_valid;
  logic       moving_up;
  logic       moving_down;

  logic       rst5 = 1'b1;
  logic [4:0] btn5 = '0;
  logic [2:0] cf5 = '0;
  logic       arr5 = 1'b0;
  logic [4:0] pend5;
  logic [2:0] tgt5;
  logic       val5;
  logic       up5;
  logic       dn5;

  int checks = 0;
  int errors = 0;

  exp_t sb[$];

  logic [7:0] m_p = '0;
  int         m_st = 0;
  logic [2:0] m_t = '0;
  logic       m_v = 1'b0;

  always #5 clk = ~clk;

  floor_request_encoder #(.FLOORS(8), .FBITS(3)) dut (
    .clk          (clk),
    .reset        (reset),
    .call_btn     (call_btn),
    .cur_floor    (cur_floor),
    .arrive       (arrive),
    .pending      (pending),
    .target       (target),
    .target_valid (target_valid),
    .moving_up    (moving_up),
    .moving_down  (moving_down)
  );

  floor_request_encoder #(.FLOORS(5), .FBITS(3)) dut5 (
    .clk          (clk),
    .reset        (rst5),
    .call_btn     (btn5),
    .cur_floor    (cf5),
    .arrive       (arr5),
    .pending      (pend5),
    .target       (tgt5),
    .target_valid (val5),
    .moving_up    (up5),
    .moving_down  (dn5)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step(input logic r, input logic [7:0] b,
                      input logic [2:0] cf, input logic a);
    exp_t e;
    int   la;
    int   hb;
    logic hr;
    @(negedge clk);
    reset     = r;
    call_btn  = b;
    cur_floor = cf;
    arrive    = a;
    if (r) begin
      m_p  = '0;
      m_st = 0;
      m_t  = '0;
      m_v  = 1'b0;
    end else begin
      la = -1;
      hb = -1;
      for (int j = 7; j > int'(cf); j--)
        if (m_p[j]) la = j;
      for (int j = 0; j < int'(cf); j++)
        if (m_p[j]) hb = j;
      hr = m_p[cf];
      case (m_st)
        0: begin
          if (la >= 0) begin
            m_st = 1; m_t = 3'(la); m_v = 1'b1;
          end else if (hb >= 0) begin
            m_st = 2; m_t = 3'(hb); m_v = 1'b1;
          end else if (hr) begin
            m_t = cf; m_v = 1'b1;
          end else m_v = 1'b0;
        end
        1: begin
          if (la >= 0) begin
            m_t = 3'(la); m_v = 1'b1;
          end else if (hb >= 0) begin
            m_st = 2; m_t = 3'(hb); m_v = 1'b1;
          end else begin
            m_st = 0; m_v = 1'b0;
          end
        end
        default: begin
          if (hb >= 0) begin
            m_t = 3'(hb); m_v = 1'b1;
          end else if (la >= 0) begin
            m_st = 1; m_t = 3'(la); m_v = 1'b1;
          end else begin
            m_st = 0; m_v = 1'b0;
          end
        end
      endcase
      m_p = (m_p | b) & ~(a ? (8'h01 << cf) : 8'h00);
    end
    sb.push_back({m_p, m_t, m_v, m_st == 1, m_st == 2});
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      chk("sb_empty", 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      chk("sb_pending", pending, e.p);
      chk("sb_target", target, e.t);
      chk("sb_valid", target_valid, e.v);
      chk("sb_up", moving_up, e.u);
      chk("sb_down", moving_down, e.d);
    end
  endtask

  initial begin
    step(1, 8'h00, 3'd0, 0);
    step(1, 8'h00, 3'd0, 0);
    chk("rst_pending", pending, 8'h00);
    chk("rst_valid", target_valid, 1'b0);
    chk("rst_target", target, 3'd0);

    step(0, 8'h20, 3'd2, 0);
    chk("tp1_pend", pending, 8'h20);
    step(0, 8'h00, 3'd2, 0);
    chk("tp1_target", target, 3'd5);
    chk("tp1_valid", target_valid, 1'b1);
    chk("tp1_up", moving_up, 1'b1);

    step(0, 8'h81, 3'd2, 0);
    chk("tp2_pend", pending, 8'hA1);
    chk("tp2_target", target, 3'd5);
    step(0, 8'h00, 3'd5, 1);
    chk("tp2_arr5_pend", pending, 8'h81);
    step(0, 8'h00, 3'd5, 0);
    chk("tp2_target7", target, 3'd7);
    step(0, 8'h00, 3'd7, 1);
    chk("tp2_arr7_pend", pending, 8'h01);
    step(0, 8'h00, 3'd7, 0);
    chk("tp2_down", moving_down, 1'b1);
    chk("tp2_target0", target, 3'd0);
    step(0, 8'h00, 3'd0, 1);
    step(0, 8'h00, 3'd0, 0);
    chk("tp2_idle_valid", target_valid, 1'b0);
    chk("tp2_idle_down", moving_down, 1'b0);

    step(0, 8'h08, 3'd3, 1);
    chk("tp3_pend", pending, 8'h00);
    step(0, 8'h00, 3'd3, 0);
    chk("tp3_valid", target_valid, 1'b0);

    step(0, 8'h10, 3'd4, 0);
    step(0, 8'h00, 3'd4, 0);
    chk("tp4_target", target, 3'd4);
    chk("tp4_valid", target_valid, 1'b1);
    chk("tp4_dir", {moving_up, moving_down}, 2'b00);
    step(0, 8'h00, 3'd4, 1);
    step(0, 8'h00, 3'd4, 0);
    chk("tp4_clear_valid", target_valid, 1'b0);

    step(0, 8'h02, 3'd6, 0);
    step(0, 8'h80, 3'd6, 0);
    chk("tp5_pend", pending, 8'h82);
    step(0, 8'h00, 3'd6, 0);
    chk("tp5_target", target, 3'd1);
    chk("tp5_down", moving_down, 1'b1);
    step(1, 8'hFF, 3'd6, 1);
    chk("tp5_rst", {pending, target, target_valid, moving_up,
                    moving_down}, 16'h0000);

    for (int n = 0; n < 400; n++)
      step(($urandom_range(0, 59) == 0),
           ($urandom_range(0, 2) == 0) ? 8'($urandom) : 8'h00,
           3'($urandom_range(0, 7)),
           ($urandom_range(0, 2) == 0));

    @(negedge clk);
    rst5 = 1'b0;
    btn5 = 5'h11;
    cf5  = 3'd7;
    @(negedge clk);
    chk("f5_pend_latch", pend5, 5'h11);
    btn5 = 5'h00;
    arr5 = 1'b1;
    @(negedge clk);
    arr5 = 1'b0;
    chk("f5_pend_kept", pend5, 5'h11);
    chk("f5_target", tgt5, 3'd4);
    chk("f5_down", dn5, 1'b1);
    chk("f5_valid", val5, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
